sd_block_arbiter: RTL and testbench

SD_BLOCK_ARBITER -- requirements
Module: sd_block_arbiter

---
 rtl/sd_arb_pkg.sv | 15 +
 rtl/sd_block_arbiter_if.sv | 39 +++
 rtl/sd_arb_rr.sv | 27 ++
 rtl/sd_block_arbiter.sv | 154 +++++++++++++++
 tb/tb_sd_block_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_arb_pkg.sv
// Shared definitions for the SD block arbiter: requester count, default
// controller timeout and the arbiter state encoding.
package sd_arb_pkg;

  localparam int          NUM_REQ            = 2;
  localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd2_000_000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RELEASE = 2'd2,
    S_FAILALL = 2'd3
  } sd_arb_state_e;

endpackage

// File: rtl/sd_block_arbiter_if.sv
// Requester-side bundle of the SD block arbiter. The master modport is the
// requester view, the slave modport is the arbiter view.
interface sd_block_arbiter_if
  import sd_arb_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic [NUM_REQ-1:0] rq_req;
  logic [NUM_REQ-1:0] rq_we;
  logic [DATA_W-1:0]  rq_addr0;
  logic [DATA_W-1:0]  rq_addr1;
  logic [DATA_W-1:0]  rq_cnt0;
  logic [DATA_W-1:0]  rq_cnt1;
  logic [DATA_W-1:0]  rq_wdata0;
  logic [DATA_W-1:0]  rq_wdata1;
  logic [NUM_REQ-1:0] rq_gnt;
  logic [NUM_REQ-1:0] rq_done;
  logic [NUM_REQ-1:0] rq_fail;
  logic [NUM_REQ-1:0] rq_wreq_valid;
  logic [NUM_REQ-1:0] rq_rd_valid;
  logic [DATA_W-1:0]  rq_data_addr;
  logic [DATA_W-1:0]  rq_rdata;

  modport master (
    output rq_req, rq_we, rq_addr0, rq_addr1, rq_cnt0, rq_cnt1,
           rq_wdata0, rq_wdata1,
    input  rq_gnt, rq_done, rq_fail, rq_wreq_valid, rq_rd_valid,
           rq_data_addr, rq_rdata
  );

  modport slave (
    input  rq_req, rq_we, rq_addr0, rq_addr1, rq_cnt0, rq_cnt1,
           rq_wdata0, rq_wdata1,
    output rq_gnt, rq_done, rq_fail, rq_wreq_valid, rq_rd_valid,
           rq_data_addr, rq_rdata
  );

endinterface

// File: rtl/sd_arb_rr.sv
// Two-way round-robin pick: the requester served last has the lowest
// priority. A cleared last-grant vector (after reset) favours requester 0.
module sd_arb_rr
  import sd_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last_gnt,
  output logic [NUM_REQ-1:0] win
);

  logic prefer_one;

  assign prefer_one = (last_gnt == 2'b01);

  // One-hot winner; requester 1 goes first only right after requester 0 was served.
  always_comb begin
    win = '0;
    if (prefer_one) begin
      if (req[1])      win = 2'b10;
      else if (req[0]) win = 2'b01;
    end else begin
      if (req[0])      win = 2'b01;
      else if (req[1]) win = 2'b10;
    end
  end

endmodule

// File: rtl/sd_block_arbiter.sv
// Two-requester arbiter in front of a single SD block controller. The owner's
// command is latched on grant and held until the controller reports
// completion or failure; data-path strobes are steered only to the owner.
// Optional feature: define SD_ARB_TIMEOUT_EN to abort a transaction that sees
// no controller response within TIMEOUT_CYCLES cycles.
module sd_block_arbiter
  import sd_arb_pkg::*;
#(
  parameter int          DATA_W         = 32,
  parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  sd_block_arbiter_if.slave rq,
  output logic [DATA_W-1:0] SD_Addr_Block,
  output logic              SD_Enable,
  output logic              SD_we,
  output logic [DATA_W-1:0] SD_SerialCount,
  output logic [DATA_W-1:0] SD_InPut_Data,
  input  logic              SD_Complite,
  input  logic              SD_Fail,
  input  logic              SD_Init_Complite,
  input  logic              SD_Init_Fail,
  input  logic              SD_InPut_Data_Valid,
  input  logic [DATA_W-1:0] SD_InPut_Data_Addr,
  input  logic              SD_Out_Data_Valid,
  input  logic [DATA_W-1:0] SD_Out_Data_Addr,
  input  logic [DATA_W-1:0] SD_Out_Data
);

  sd_arb_state_e      state;
  logic [NUM_REQ-1:0] last_gnt;
  logic [NUM_REQ-1:0] win;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] fail;
  logic               sel_we;
  logic [DATA_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_cnt;
  logic               tmo_hit;
  logic               run_fail;

  sd_arb_rr u_rr (
    .req      (rq.rq_req),
    .last_gnt (last_gnt),
    .win      (win)
  );

  // Command fields of the round-robin winner, ready to be latched on grant.
  always_comb begin
    sel_we   = rq.rq_we[0];
    sel_addr = rq.rq_addr0;
    sel_cnt  = rq.rq_cnt0;
    if (win[1]) begin
      sel_we   = rq.rq_we[1];
      sel_addr = rq.rq_addr1;
      sel_cnt  = rq.rq_cnt1;
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Cycles spent in S_RUN; held at zero outside it so every transaction starts fresh.
  always_ff @(posedge clk) begin
    if (rst || state != S_RUN) tmo_cnt <= '0;
    else                       tmo_cnt <= tmo_cnt + 32'd1;
  end

  assign tmo_hit = (state == S_RUN) && (tmo_cnt == TIMEOUT_CYCLES - 32'd1);
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // A simultaneous complete+fail is reported as a failure.
  assign run_fail = SD_Fail | tmo_hit;

  // Arbitration state machine; done/fail are single-cycle pulses cleared by default.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      last_gnt       <= '0;
      gnt            <= '0;
      done           <= '0;
      fail           <= '0;
      SD_Enable      <= 1'b0;
      SD_we          <= 1'b0;
      SD_Addr_Block  <= '0;
      SD_SerialCount <= '0;
    end else begin
      done <= '0;
      fail <= '0;
      case (state)
        S_IDLE: begin
          if (|rq.rq_req) begin
            if (SD_Init_Fail) begin
              fail     <= win;
              last_gnt <= win;
              state    <= S_FAILALL;
            end else if (SD_Init_Complite && !SD_Complite) begin
              gnt            <= win;
              last_gnt       <= win;
              SD_Enable      <= 1'b1;
              SD_we          <= sel_we;
              SD_Addr_Block  <= sel_addr;
              SD_SerialCount <= sel_cnt;
              state          <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (run_fail || SD_Complite) begin
            if (run_fail) fail <= gnt;
            else          done <= gnt;
            gnt       <= '0;
            SD_Enable <= 1'b0;
            SD_we     <= 1'b0;
            state     <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!SD_Complite) state <= S_IDLE;
        end
        S_FAILALL: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Owner-gated strobes and write data; shared read/address paths forced to 0 in reset.
  always_comb begin
    rq.rq_wreq_valid = gnt & {NUM_REQ{SD_InPut_Data_Valid}};
    rq.rq_rd_valid   = gnt & {NUM_REQ{SD_Out_Data_Valid}};
    SD_InPut_Data    = '0;
    if (gnt[1])      SD_InPut_Data = rq.rq_wdata1;
    else if (gnt[0]) SD_InPut_Data = rq.rq_wdata0;
    rq.rq_data_addr  = '0;
    if (!rst) begin
      if (SD_InPut_Data_Valid)    rq.rq_data_addr = SD_InPut_Data_Addr;
      else if (SD_Out_Data_Valid) rq.rq_data_addr = SD_Out_Data_Addr;
    end
    rq.rq_rdata = rst ? '0 : SD_Out_Data;
  end

  assign rq.rq_gnt  = gnt;
  assign rq.rq_done = done;
  assign rq.rq_fail = fail;

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Self-checking bench for sd_block_arbiter: directed sequences, a vector
// table for the owner-gated data paths, and randomized transactions checked
// against a transaction-level round-robin model.
module tb_sd_block_arbiter;
  import sd_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] SD_Addr_Block, SD_SerialCount, SD_InPut_Data;
  logic        SD_Enable, SD_we;
  logic        SD_Complite, SD_Fail, SD_Init_Complite, SD_Init_Fail;
  logic        SD_InPut_Data_Valid, SD_Out_Data_Valid;
  logic [31:0] SD_InPut_Data_Addr, SD_Out_Data_Addr, SD_Out_Data;

  int n_pass  = 0;
  int n_total = 0;

  sd_block_arbiter_if bus ();

  sd_block_arbiter #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rq                  (bus),
    .SD_Addr_Block       (SD_Addr_Block),
    .SD_Enable           (SD_Enable),
    .SD_we               (SD_we),
    .SD_SerialCount      (SD_SerialCount),
    .SD_InPut_Data       (SD_InPut_Data),
    .SD_Complite         (SD_Complite),
    .SD_Fail             (SD_Fail),
    .SD_Init_Complite    (SD_Init_Complite),
    .SD_Init_Fail        (SD_Init_Fail),
    .SD_InPut_Data_Valid (SD_InPut_Data_Valid),
    .SD_InPut_Data_Addr  (SD_InPut_Data_Addr),
    .SD_Out_Data_Valid   (SD_Out_Data_Valid),
    .SD_Out_Data_Addr    (SD_Out_Data_Addr),
    .SD_Out_Data         (SD_Out_Data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        iv;
    logic        ov;
    logic [31:0] ia;
    logic [31:0] oa;
    logic [31:0] od;
    logic [31:0] wd1;
    logic [1:0]  e_wv;
    logic [1:0]  e_rv;
    logic [31:0] e_da;
    logic [31:0] e_rd;
    logic [31:0] e_wd;
  } cvec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rq_req = 2'b00; bus.rq_we = 2'b00;
    bus.rq_addr0 = '0; bus.rq_addr1 = '0; bus.rq_cnt0 = '0; bus.rq_cnt1 = '0;
    bus.rq_wdata0 = '0; bus.rq_wdata1 = '0;
    SD_Complite = 0; SD_Fail = 0; SD_Init_Complite = 1; SD_Init_Fail = 0;
    SD_InPut_Data_Valid = 0; SD_Out_Data_Valid = 0;
    SD_InPut_Data_Addr = '0; SD_Out_Data_Addr = '0; SD_Out_Data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_cmd(input int r, input logic we, input logic [31:0] a, input logic [31:0] c);
    bus.rq_we[r] = we;
    if (r == 0) begin bus.rq_addr0 = a; bus.rq_cnt0 = c; end
    else        begin bus.rq_addr1 = a; bus.rq_cnt1 = c; end
    bus.rq_req[r] = 1'b1;
  endtask

  task automatic wait_gnt(input int budget, output logic [1:0] g);
    g = 2'b00;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (bus.rq_gnt != 2'b00) begin
        g = bus.rq_gnt;
        break;
      end
    end
  endtask

  initial begin
    cvec_t       tv[4];
    logic [1:0]  g;
    logic [1:0]  fseen;
    logic        en_seen;
    int          got;
    int          last_served;
    bit          pend[2];
    logic        mw[2];
    logic [31:0] ma[2], mc[2];

    tv[0] = '{iv:1, ov:0, ia:32'h3,  oa:32'h9,  od:32'hAA,       wd1:32'hCAFE0001,
              e_wv:2'b10, e_rv:2'b00, e_da:32'h3,  e_rd:32'hAA,       e_wd:32'hCAFE0001};
    tv[1] = '{iv:0, ov:1, ia:32'h3,  oa:32'h9,  od:32'h5555AAAA, wd1:32'hCAFE0002,
              e_wv:2'b00, e_rv:2'b10, e_da:32'h9,  e_rd:32'h5555AAAA, e_wd:32'hCAFE0002};
    tv[2] = '{iv:0, ov:0, ia:32'h44, oa:32'h88, od:32'h0BADF00D, wd1:32'h12345678,
              e_wv:2'b00, e_rv:2'b00, e_da:32'h0,  e_rd:32'h0BADF00D, e_wd:32'h12345678};
    tv[3] = '{iv:1, ov:0, ia:32'h70, oa:32'h80, od:32'h1,        wd1:32'hFFFFFFFF,
              e_wv:2'b10, e_rv:2'b00, e_da:32'h70, e_rd:32'h1,        e_wd:32'hFFFFFFFF};

    // Reset: every output must read 0, even with live controller inputs.
    idle_inputs();
    rst = 1'b1;
    SD_Out_Data = 32'hDEADBEEF; SD_Out_Data_Valid = 1; SD_Out_Data_Addr = 32'h55;
    bus.rq_req = 2'b11;
    tick();
    tick();
    chk("rst_enable", SD_Enable, 0);
    chk("rst_gnt", bus.rq_gnt, 0);
    chk("rst_done_fail", {bus.rq_done, bus.rq_fail}, 0);
    chk("rst_cmd", {SD_Addr_Block ^ SD_SerialCount, 31'b0, SD_we}, 0);
    chk("rst_rdata", bus.rq_rdata, 0);
    chk("rst_data_addr", bus.rq_data_addr, 0);
    chk("rst_valids", {bus.rq_rd_valid, bus.rq_wreq_valid}, 0);
    do_reset();

    // Single read from requester 0.
    set_cmd(0, 1'b0, 32'h10, 32'h0);
    tick();
    chk("r0_enable", SD_Enable, 1);
    chk("r0_gnt", bus.rq_gnt, 2'b01);
    chk("r0_addr", SD_Addr_Block, 32'h10);
    chk("r0_we", SD_we, 0);
    chk("r0_cnt", SD_SerialCount, 0);
    bus.rq_addr0 = 32'h999; bus.rq_we[0] = 1'b1; bus.rq_req[0] = 1'b0;
    tick();
    chk("r0_hold_addr", SD_Addr_Block, 32'h10);
    chk("r0_hold_enable", SD_Enable, 1);
    SD_Complite = 1;
    tick();
    chk("r0_done", bus.rq_done, 2'b01);
    chk("r0_enable_drop", SD_Enable, 0);
    chk("r0_gnt_drop", bus.rq_gnt, 0);
    SD_Complite = 0;
    tick();
    chk("r0_done_pulse", bus.rq_done, 0);

    // No grant while the card is not initialised.
    SD_Init_Complite = 0;
    set_cmd(0, 1'b0, 32'h20, 32'h0);
    tick();
    tick();
    chk("noinit_enable", SD_Enable, 0);
    chk("noinit_gnt", bus.rq_gnt, 0);
    bus.rq_req = 2'b00;
    SD_Init_Complite = 1;

    // Simultaneous requests after reset alternate 0,1,0,1.
    do_reset();
    set_cmd(0, 1'b0, 32'hA0, 32'h0);
    set_cmd(1, 1'b1, 32'hB0, 32'h2);
    for (int i = 0; i < 4; i++) begin
      wait_gnt(3, g);
      chk($sformatf("rr_gnt_%0d", i), g, (i % 2 == 0) ? 2'b01 : 2'b10);
      SD_Complite = 1;
      tick();
      chk($sformatf("rr_done_%0d", i), bus.rq_done, g);
      SD_Complite = 0;
      bus.rq_req = 2'b00;
      tick();
      bus.rq_req = 2'b11;
    end
    bus.rq_req = 2'b00;
    tick();
    tick();

    // Requester 1 write: owner-gated strobes and write data, table-driven.
    do_reset();
    bus.rq_wdata0 = 32'h11111111;
    set_cmd(1, 1'b1, 32'h7, 32'h1);
    tick();
    chk("w1_gnt", bus.rq_gnt, 2'b10);
    chk("w1_we", SD_we, 1);
    chk("w1_addr", SD_Addr_Block, 32'h7);
    chk("w1_cnt", SD_SerialCount, 32'h1);
    for (int i = 0; i < 4; i++) begin
      SD_InPut_Data_Valid = tv[i].iv; SD_Out_Data_Valid = tv[i].ov;
      SD_InPut_Data_Addr = tv[i].ia;  SD_Out_Data_Addr = tv[i].oa;
      SD_Out_Data = tv[i].od;         bus.rq_wdata1 = tv[i].wd1;
      #1;
      chk($sformatf("tv%0d_wreq_valid", i), bus.rq_wreq_valid, tv[i].e_wv);
      chk($sformatf("tv%0d_rd_valid", i), bus.rq_rd_valid, tv[i].e_rv);
      chk($sformatf("tv%0d_data_addr", i), bus.rq_data_addr, tv[i].e_da);
      chk($sformatf("tv%0d_rdata", i), bus.rq_rdata, tv[i].e_rd);
      chk($sformatf("tv%0d_wdata", i), SD_InPut_Data, tv[i].e_wd);
      tick();
    end
    SD_InPut_Data_Valid = 0; SD_Out_Data_Valid = 0;
    SD_Complite = 1;
    tick();
    chk("w1_done", bus.rq_done, 2'b10);
    SD_Complite = 0;
    bus.rq_req = 2'b00;
    tick();

    // Complete and fail together count as failure; next grant waits for Complite low.
    set_cmd(0, 1'b0, 32'h30, 32'h0);
    tick();
    chk("f_gnt", bus.rq_gnt, 2'b01);
    SD_Fail = 1; SD_Complite = 1;
    tick();
    chk("f_fail", bus.rq_fail, 2'b01);
    chk("f_done", bus.rq_done, 2'b00);
    chk("f_enable", SD_Enable, 0);
    SD_Fail = 0;
    bus.rq_req = 2'b10;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("f_hold_gnt_%0d", k), {bus.rq_gnt, SD_Enable}, 0);
    end
    SD_Complite = 0;
    tick();
    tick();
    chk("f_regrant", bus.rq_gnt, 2'b10);

    // Reset mid-transaction: enable drops, no pulses, pointer back to requester 0.
    rst = 1'b1;
    tick();
    chk("mid_rst_enable", SD_Enable, 0);
    chk("mid_rst_pulses", {bus.rq_done, bus.rq_fail, bus.rq_gnt}, 0);
    rst = 1'b0;
    bus.rq_req = 2'b11;
    tick();
    chk("mid_rst_ptr", bus.rq_gnt, 2'b01);
    SD_Complite = 1;
    tick();
    SD_Complite = 0;
    bus.rq_req = 2'b00;
    tick();

    // Initialisation failure: fail pulse to the requester, controller never enabled.
    do_reset();
    SD_Init_Fail = 1;
    set_cmd(0, 1'b0, 32'h40, 32'h0);
    fseen = 2'b00;
    en_seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      en_seen = en_seen | SD_Enable;
      if (bus.rq_fail != 2'b00) begin
        fseen = bus.rq_fail;
        break;
      end
    end
    chk("initfail_fail", fseen, 2'b01);
    bus.rq_req = 2'b00;
    for (int k = 0; k < 3; k++) begin
      tick();
      en_seen = en_seen | SD_Enable;
    end
    chk("initfail_no_enable", en_seen, 0);
    SD_Init_Fail = 0;

`ifdef SD_ARB_TIMEOUT_EN
    // Silent controller: failure pulse appears in cycle 101 counted from entering S_RUN.
    do_reset();
    set_cmd(0, 1'b0, 32'h50, 32'h0);
    tick();
    got = -1;
    for (int k = 1; k < 130; k++) begin
      tick();
      if (bus.rq_fail != 2'b00) begin
        got = k + 1;
        break;
      end
    end
    chk("timeout_cycle", got, 101);
    bus.rq_req = 2'b00;
    tick();
`else
    // Silent controller: the transaction is simply held open.
    do_reset();
    set_cmd(0, 1'b0, 32'h50, 32'h0);
    tick();
    got = 0;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (SD_Enable && bus.rq_fail == 2'b00) got++;
    end
    chk("no_timeout", got, 150);
    SD_Complite = 1;
    tick();
    SD_Complite = 0;
    bus.rq_req = 2'b00;
    tick();
`endif

    // Randomized transactions against a transaction-level round-robin model.
    do_reset();
    last_served = -1;
    pend[0] = 0; pend[1] = 0;
    for (int t = 0; t < 40; t++) begin
      int          w;
      int          outcome;
      logic [1:0]  oh;
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) != 0) begin
          pend[r] = 1;
          mw[r] = 1'($urandom_range(0, 1));
          ma[r] = $urandom;
          mc[r] = $urandom_range(0, 8);
          set_cmd(r, mw[r], ma[r], mc[r]);
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1; mw[0] = 1'b0; ma[0] = $urandom; mc[0] = 32'h0;
        set_cmd(0, mw[0], ma[0], mc[0]);
      end
      if (pend[0] && pend[1]) w = (last_served == 0) ? 1 : 0;
      else                    w = pend[0] ? 0 : 1;
      oh = (w == 0) ? 2'b01 : 2'b10;

      wait_gnt(3, g);
      chk("rand_gnt", g, oh);
      chk("rand_addr", SD_Addr_Block, ma[w]);
      chk("rand_cnt", SD_SerialCount, mc[w]);
      chk("rand_we", SD_we, mw[w]);

      for (int h = $urandom_range(0, 3); h > 0; h--) begin
        logic [31:0] wd;
        wd = $urandom;
        if (w == 0) begin bus.rq_addr0 = $urandom; bus.rq_wdata0 = wd; end
        else        begin bus.rq_addr1 = $urandom; bus.rq_wdata1 = wd; end
        bus.rq_req[w] = 1'($urandom_range(0, 1));
        SD_InPut_Data_Valid = 1'($urandom_range(0, 1));
        SD_Out_Data_Valid = 1'($urandom_range(0, 1));
        #1;
        chk("rand_wreq_valid", bus.rq_wreq_valid, SD_InPut_Data_Valid ? oh : 2'b00);
        chk("rand_rd_valid", bus.rq_rd_valid, SD_Out_Data_Valid ? oh : 2'b00);
        chk("rand_wdata", SD_InPut_Data, wd);
        tick();
        chk("rand_hold", {SD_Addr_Block, 31'b0, SD_Enable}, {ma[w], 32'h1});
      end
      SD_InPut_Data_Valid = 0; SD_Out_Data_Valid = 0;

      outcome = $urandom_range(0, 2);
      SD_Complite = (outcome != 1);
      SD_Fail = (outcome != 0);
      tick();
      chk("rand_done", bus.rq_done, (outcome == 0) ? oh : 2'b00);
      chk("rand_fail", bus.rq_fail, (outcome != 0) ? oh : 2'b00);
      chk("rand_end_enable", SD_Enable, 0);
      SD_Fail = 0;
      pend[w] = 0;
      bus.rq_req[w] = 1'b0;
      last_served = w;
      SD_Complite = (outcome != 1) && ($urandom_range(0, 1) == 1);
      for (int h = $urandom_range(0, 2); h > 0 && SD_Complite; h--) begin
        tick();
        chk("rand_release_gnt", {bus.rq_gnt, SD_Enable}, 0);
      end
      SD_Complite = 0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
